// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: addi in 4 cycles (FETCH-DECODE-EXEC_I-WB), beq/bne in 3 (FETCH-DECODE-EXEC_B).
// The FETCH wait on imem_ack is unbounded; unsupported encodings park the core in HALT until rst.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 imem_ack,
  input  logic                 zero,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 imm_src,
  output logic                 alu_src,
  output logic [2:0]           alu_ctrl,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic                 pc_src,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC_I = 3'd2,
    S_WB     = 3'd3,
    S_EXEC_B = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;

  state_t                 state_q, state_d;
  logic                   illegal_q, illegal_d;
  logic                   is_bne_q, is_bne_d;
  logic [CNT_WIDTH-1:0]   retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31:15], instr[11:7]};

  assign illegal = illegal_q;
  assign retired = retired_q;

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    is_bne_d  = is_bne_q;
    retired_d = retired_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    imm_src   = 1'b0;
    alu_src   = 1'b0;
    alu_ctrl  = ALU_ADD;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
        if (imem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_IMM && funct3 == 3'b000) begin
          state_d = S_EXEC_I;
        end else if (opcode == OP_BRANCH && funct3[2:1] == 2'b00) begin
          state_d  = S_EXEC_B;
          is_bne_d = funct3[0];
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC_I: begin
        alu_src = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_B: begin
        imm_src   = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_write  = 1'b1;
        // Branch taken when the SUB result matches the captured condition.
        pc_src    = is_bne_q ? ~zero : zero;
        retired_d = retired_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Reset aborts any in-flight instruction, so no strobe may escape this cycle.
    if (rst) begin
      imem_req  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      is_bne_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      is_bne_q  <= is_bne_d;
      retired_q <= retired_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-sequence model plus directed literal checks,
// driving a default-width instance and a CNT_WIDTH=2 instance from the same stimulus.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ack = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] instr = 32'h0;

  logic        a_imem_req, a_ir_write, a_imm_src, a_alu_src, a_reg_write, a_pc_write, a_pc_src, a_illegal;
  logic [2:0]  a_alu_ctrl;
  logic [15:0] a_retired;
  logic        b_imem_req, b_ir_write, b_imm_src, b_alu_src, b_reg_write, b_pc_write, b_pc_src, b_illegal;
  logic [2:0]  b_alu_ctrl;
  logic [1:0]  b_retired;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut_a (
    .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .zero(zero),
    .imem_req(a_imem_req), .ir_write(a_ir_write), .imm_src(a_imm_src), .alu_src(a_alu_src),
    .alu_ctrl(a_alu_ctrl), .reg_write(a_reg_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .illegal(a_illegal), .retired(a_retired)
  );

  multicycle_ctrl #(.CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .instr(instr), .imem_ack(imem_ack), .zero(zero),
    .imem_req(b_imem_req), .ir_write(b_ir_write), .imm_src(b_imm_src), .alu_src(b_alu_src),
    .alu_ctrl(b_alu_ctrl), .reg_write(b_reg_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .illegal(b_illegal), .retired(b_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: each fetched instruction expands into a list of cycle records
  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       imm_src;
    logic       alu_src;
    logic [2:0] alu_ctrl;
    logic       reg_write;
    logic       pc_write;
    logic [1:0] pc_kind;   // 0: pc_src=0, 1: pc_src=zero, 2: pc_src=!zero
    logic       retire;
    logic       halt;
  } rec_t;

  rec_t q[$];
  bit   model_on = 0;
  bit   halted = 0;
  bit   m_ill = 0;
  int   m_ret = 0;

  task automatic push_instr(input logic [31:0] w);
    rec_t       r;
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    r  = '0;
    if (op == 7'b0010011 && f3 == 3'b000) begin
      q.push_back(r);
      r.alu_src = 1'b1;
      q.push_back(r);
      r.reg_write = 1'b1; r.pc_write = 1'b1; r.retire = 1'b1;
      q.push_back(r);
    end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      q.push_back(r);
      r.imm_src = 1'b1; r.alu_ctrl = 3'b001; r.pc_write = 1'b1; r.retire = 1'b1;
      r.pc_kind = (f3 == 3'b001) ? 2'd2 : 2'd1;
      q.push_back(r);
    end else begin
      r.halt = 1'b1;
      q.push_back(r);
    end
  endtask

  always @(negedge clk) begin : model_cmp
    rec_t        e;
    rec_t        popped;
    logic        pcs;
    logic [10:0] ev;
    if (model_on) begin
      e = '0;
      if (!halted && q.size() != 0) e = q[0];
      else if (!halted) begin
        e.imem_req = 1'b1;
        e.ir_write = imem_ack;
      end
      pcs = (e.pc_kind == 2'd1) ? zero : (e.pc_kind == 2'd2) ? ~zero : 1'b0;
      if (rst) begin
        e.imem_req = 1'b0; e.ir_write = 1'b0; e.reg_write = 1'b0; e.pc_write = 1'b0;
      end
      ev = {e.imem_req, e.ir_write, e.imm_src, e.alu_src, e.alu_ctrl, e.reg_write, e.pc_write, pcs, m_ill};
      chk("ctl_a", {21'd0, a_imem_req, a_ir_write, a_imm_src, a_alu_src, a_alu_ctrl, a_reg_write, a_pc_write, a_pc_src, a_illegal}, {21'd0, ev});
      chk("ctl_b", {21'd0, b_imem_req, b_ir_write, b_imm_src, b_alu_src, b_alu_ctrl, b_reg_write, b_pc_write, b_pc_src, b_illegal}, {21'd0, ev});
      chk("ret_a", {16'd0, a_retired}, m_ret % 65536);
      chk("ret_b", {30'd0, b_retired}, m_ret % 4);
    end
    // Advance to the state after the coming rising edge; inputs hold until then.
    if (rst) begin
      q.delete();
      halted   = 0;
      m_ill    = 0;
      m_ret    = 0;
      model_on = 1;
    end else if (model_on && !halted) begin
      if (q.size() != 0) begin
        popped = q.pop_front();
        if (popped.retire) m_ret++;
        if (popped.halt) begin
          halted = 1;
          m_ill  = 1;
        end
      end else if (imem_ack) begin
        push_instr(instr);
      end
    end
  end

  // ---------------- directed stimulus with literal expectations
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_branch(input logic [31:0] w, input logic z, input logic exp_pcs, input string tag);
    step(); instr = w; imem_ack = 1'b1; zero = z;
    step();                                     // DECODE; ack held high must be ignored
    step(); imem_ack = 1'b0;                    // EXEC_B
    @(negedge clk);
    chk({tag, "_imm_src"}, {31'd0, a_imm_src}, 32'd1);
    chk({tag, "_alu_ctrl"}, {29'd0, a_alu_ctrl}, 32'd1);
    chk({tag, "_pc_write"}, {31'd0, a_pc_write}, 32'd1);
    chk({tag, "_pc_src"}, {31'd0, a_pc_src}, {31'd0, exp_pcs});
  endtask

  task automatic run_addi(input logic [1:0] exp_ret_b_before);
    step(); instr = 32'h0050_0093; imem_ack = 1'b1;
    @(negedge clk);
    chk("b2b_ret_b", {30'd0, b_retired}, {30'd0, exp_ret_b_before});
    step(); imem_ack = 1'b0;
    step();
    step();
  endtask

  initial begin
    step(); step();
    @(negedge clk);
    chk("rst_imem_req", {31'd0, a_imem_req}, 32'd0);
    step(); rst = 1'b0; imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_imem_req", {31'd0, a_imem_req}, 32'd1);
      chk("idle_ir_write", {31'd0, a_ir_write}, 32'd0);
      chk("idle_retired", {16'd0, a_retired}, 32'd0);
      step();
    end

    // addi x1,x0,5
    instr = 32'h0050_0093; imem_ack = 1'b1;
    @(negedge clk);
    chk("addi_c1_ir_write", {31'd0, a_ir_write}, 32'd1);
    step(); imem_ack = 1'b0;
    @(negedge clk);
    chk("addi_c2_strobes", {30'd0, a_reg_write, a_pc_write}, 32'd0);
    step();
    @(negedge clk);
    chk("addi_c3_alu_src", {31'd0, a_alu_src}, 32'd1);
    chk("addi_c3_reg_write", {31'd0, a_reg_write}, 32'd0);
    step();
    @(negedge clk);
    chk("addi_c4_alu_src", {31'd0, a_alu_src}, 32'd1);
    chk("addi_c4_wr", {29'd0, a_reg_write, a_pc_write, a_pc_src}, 32'b110);
    chk("addi_c4_retired", {16'd0, a_retired}, 32'd0);
    step();
    @(negedge clk);
    chk("addi_retired", {16'd0, a_retired}, 32'd1);

    run_branch(32'hFE10_1EE3, 1'b0, 1'b1, "bne_z0");
    run_branch(32'hFE10_1EE3, 1'b1, 1'b0, "bne_z1");
    run_branch(32'hFE10_0EE3, 1'b1, 1'b1, "beq_z1");
    run_branch(32'hFE10_0EE3, 1'b0, 1'b0, "beq_z0");
    step(); zero = 1'b0;
    @(negedge clk);
    chk("br_retired", {16'd0, a_retired}, 32'd5);

    // R-type add: unsupported, must halt
    instr = 32'h0000_0033; imem_ack = 1'b1;
    step(); imem_ack = 1'b0;
    @(negedge clk);
    chk("rtype_decode_illegal", {31'd0, a_illegal}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(); imem_ack = (i % 2 == 0);
      @(negedge clk);
      chk("halt_state", {28'd0, a_illegal, a_imem_req, a_reg_write, a_pc_write}, 32'b1000);
    end
    step(); rst = 1'b1; imem_ack = 1'b0;
    @(negedge clk);
    chk("halt_rst_strobe", {31'd0, a_imem_req}, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_illegal", {31'd0, a_illegal}, 32'd0);
    chk("halt_rst_fetch", {31'd0, a_imem_req}, 32'd1);

    // Back-to-back addi; narrow counter wraps 1,2,3,0,1
    run_addi(2'd0);
    run_addi(2'd1);
    run_addi(2'd2);
    run_addi(2'd3);
    run_addi(2'd0);
    step(); imem_ack = 1'b0;
    @(negedge clk);
    chk("wrap_ret_b", {30'd0, b_retired}, 32'd1);
    chk("wrap_ret_a", {16'd0, a_retired}, 32'd5);

    // Reset during EXEC_I aborts the addi
    step(); instr = 32'h0050_0093; imem_ack = 1'b1;
    step(); imem_ack = 1'b0;
    step(); rst = 1'b1;
    @(negedge clk);
    chk("abort_c3_reg_write", {31'd0, a_reg_write}, 32'd0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("abort_c4_reg_write", {30'd0, a_reg_write, a_pc_write}, 32'd0);
    chk("abort_c4_fetch", {31'd0, a_imem_req}, 32'd1);
    chk("abort_retired_a", {16'd0, a_retired}, 32'd0);
    chk("abort_retired_b", {30'd0, b_retired}, 32'd0);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
